// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO write-port round-robin arbiter.
package fifo_arb_pkg;

  localparam int N_REQ_DEF     = 4;
  localparam int DW_DEF        = 8;
  localparam int MAX_BURST_DEF = 4;
  localparam int CNT_W         = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic int gid_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer handshake plus FIFO write-side signals shared by the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int N_REQ = fifo_arb_pkg::N_REQ_DEF,
  parameter int DW    = fifo_arb_pkg::DW_DEF
);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ*DW-1:0] req_data;
  logic [N_REQ-1:0]    req_ready;
  logic                fifo_full;
  logic                fifo_wr_en;
  logic [DW-1:0]       fifo_wr_data;

  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_wr_en, fifo_wr_data
  );

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_wr_en, fifo_wr_data
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or above start, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int IW    = gid_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    start,
  output logic             found,
  output logic [IW-1:0]    index
);

  logic [IW-1:0] pos_s;

  // Scan from the farthest offset down so the nearest match wins.
  always_comb begin
    found = 1'b0;
    index = '0;
    pos_s = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      pos_s = IW'((int'(start) + i) % N_REQ);
      if (req[pos_s]) begin
        found = 1'b1;
        index = pos_s;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ byte producers.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int N_REQ     = N_REQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int IW        = gid_width(N_REQ)
) (
  input  logic              clk,
  input  logic              rst,
  fifo_wr_arbiter_if.slave  bus,
  output logic [IW-1:0]     grant_id,
  output logic              busy
);

  state_e           state_q, state_d;
  logic [IW-1:0]    gid_q, gid_d;
  logic [IW-1:0]    last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IW-1:0]    start_s;
  logic [IW-1:0]    pick_idx_s;
  logic             pick_found_s;
  logic             grant_s;
  logic             accept_s;
  logic             release_s;

  // last_q always equals the current owner while granted, so one start serves both cases.
  assign start_s   = (last_q == IW'(N_REQ - 1)) ? '0 : last_q + IW'(1);
  assign grant_s   = (state_q == ST_GRANT);
  assign accept_s  = grant_s && bus.req_valid[gid_q] && !bus.fifo_full;
  assign release_s = grant_s && (!bus.req_valid[gid_q] ||
                     (accept_s && ((cnt_q + CNT_W'(1)) == CNT_W'(MAX_BURST))));

  rr_pick #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req   (bus.req_valid),
    .start (start_s),
    .found (pick_found_s),
    .index (pick_idx_s)
  );

  // Next-state: grant from idle, release and re-arbitrate, or count beats.
  always_comb begin
    state_d = state_q;
    gid_d   = gid_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found_s) begin
          state_d = ST_GRANT;
          gid_d   = pick_idx_s;
          last_d  = pick_idx_s;
          cnt_d   = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (release_s) begin
          cnt_d = '0;
          if (pick_found_s) begin
            gid_d  = pick_idx_s;
            last_d = pick_idx_s;
          end else begin
            state_d = ST_IDLE;
          end
        end else if (accept_s) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gid_q   <= '0;
      last_q  <= IW'(N_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gid_q   <= gid_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Handshake and write port; rst blocks any transfer in the reset cycle.
  always_comb begin
    bus.req_ready    = '0;
    bus.fifo_wr_en   = 1'b0;
    bus.fifo_wr_data = '0;
    if (grant_s) begin
      bus.fifo_wr_data = bus.req_data[int'(gid_q) * DW +: DW];
    end else begin
      bus.fifo_wr_data = '0;
    end
    if (grant_s && !rst) begin
      bus.req_ready[gid_q] = !bus.fifo_full;
      bus.fifo_wr_en       = accept_s;
    end else begin
      bus.fifo_wr_en = 1'b0;
    end
  end

  assign grant_id = gid_q;
  assign busy     = grant_s;

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single write port of the 8-bit FIFO among N_REQ independent producers. Each producer offers bytes with a valid/ready handshake. The arbiter grants one producer at a time for a burst of up to MAX_BURST accepted bytes, then drives the FIFO's write enable and write data. It sits directly in front of the FIFO write side and uses the FIFO full flag for back-pressure.

## Interface
- N_REQ, default 4: number of producers (2..8).
- DW, default 8: data width; must match the FIFO data width.
- MAX_BURST, default 4: maximum accepted beats per grant (1..15).
- clk  in  1  rising-edge clock.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- req_valid  in  N_REQ  per-producer data valid.
- req_data  in  N_REQ*DW  producer data, producer i occupies bits [i*DW +: DW].
- req_ready  out  N_REQ  per-producer accept strobe; a beat transfers when valid && ready.
- fifo_full  in  1  FIFO full flag.
- fifo_wr_en  out  1  FIFO write enable.
- fifo_wr_data  out  DW  FIFO write data.
- grant_id  out  clog2(N_REQ)  index of the current owner; valid when busy=1.
- busy  out  1  a grant is held (state GRANT).

## Operation
- FSM has two states.
  - IDLE: no owner.
  - GRANT: one owner, held in registered grant_id.
- IDLE → GRANT at the edge after any req_valid is high. The winner is the first valid index searching upward from (last_owner+1) mod N_REQ.
- In GRANT, the following outputs are combinational from registered state plus the current cycle inputs:
  - req_ready[grant_id] = !fifo_full.
  - All other req_ready bits = 0.
  - fifo_wr_en = req_valid[grant_id] && !fifo_full.
  - fifo_wr_data = req_data[grant_id].
- In IDLE: req_ready=0, fifo_wr_en=0, fifo_wr_data=0.
- The 4-bit beat counter increments on each accepted beat and clears on every new grant.
- A grant is released at the clock edge when either condition holds:
  - (a) the owner's req_valid is low in that cycle;
  - (b) an accepted beat brings the counter to MAX_BURST.
- On release, re-arbitrate in the same cycle, searching from owner+1, so the previous owner has lowest priority.
  - If any producer is valid, stay in GRANT with the new owner. There is no bubble.
  - If no producer is valid, go to IDLE.
- If the owner is the only valid producer at a MAX_BURST release, it is re-granted immediately and the counter clears.
- fifo_full high during GRANT: no beats are accepted, the counter holds, and the grant is held. A full FIFO never causes a release or preemption.
- last_owner is updated on every grant.

## Timing
- Reset values:
  - State IDLE, busy=0, grant_id=0.
  - last_owner=N_REQ-1, so producer 0 has highest priority first.
  - Counter 0, req_ready=0, fifo_wr_en=0, fifo_wr_data=0.
- Arbitration latency from IDLE is 1 cycle: valid at edge k gives ready at cycle k+1.
- Data latency is 0: a beat is written to the FIFO in the same cycle it is accepted.
- Reset asserted mid-burst: at the next edge, return to IDLE and clear all state. The beat presented in the reset cycle is not written, because fifo_wr_en is forced 0 while rst=1.
- Producers must hold req_valid and req_data stable until the beat is accepted. A producer may drop valid at any time; dropping valid releases the grant.
- Throughput is 1 beat/cycle within a burst and across handoffs.

## Structure
- Shared package fifo_arb_pkg holds:
  - state encoding constants ST_IDLE=0 and ST_GRANT=1;
  - default N_REQ, DW and MAX_BURST;
  - the width function for grant_id.
- One sub-module: rr_pick. It is a combinational round-robin picker with inputs req vector and start index, and outputs found and index. It is instantiated once and used for both the IDLE grant and the release-time re-arbitration.

## Test plan
- After reset, only req_valid[2] is high with data 0xA0..0xA5. Required response:
  - grant_id=2 one cycle later;
  - writes 0xA0..0xA3 (MAX_BURST=4);
  - re-grant to 2 with no bubble;
  - writes 0xA4, 0xA5.
  - Then valid drops and the FSM returns to IDLE.
- All 4 producers valid continuously. Required response: grants rotate 0,1,2,3,0 with 4 beats each, and fifo_wr_en is high every cycle after the first.
- Owner 1 drops valid after 2 beats while producer 3 is valid. Required response: at the next edge grant_id=3, the counter is 0, and there is no idle cycle.
- fifo_full asserted for 5 cycles mid-burst after beat 2. Required response:
  - req_ready=0 and fifo_wr_en=0 for 5 cycles;
  - grant held;
  - beats 3 and 4 complete after full deasserts, then release.
- rst pulsed for 1 cycle during a burst with valid high. Required response:
  - no write in the rst cycle;
  - IDLE next cycle;
  - next grant goes to producer 0 if it is valid.
- Producers 0 and 3 valid, last_owner=0. Required response: producer 3 is granted first and producer 0 after it.
